fwd_ctrl_unit: RTL and testbench

- Generates the 2-bit select codes that drive the EX-stage 3:1 operand multiplexers (operand A and operand B) of the pipelined MIPS core.
- Tracks destination-register and control information of in-flight instructions through internal EX/MEM/WB shadow registers.
- Detects load-use hazards and asserts a one-cycle stall that inserts a bubble into EX.

---
 rtl/fwd_ctrl_unit.sv | 187 ++++++++++++++++++
 tb/tb_fwd_ctrl_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: EX-stage operand forwarding selects and load-use stall
// detection for the pipelined MIPS core.
//
// A shadow copy of the EX/MEM/WB pipeline registers (destination register
// and control bits only) is kept here so that forwarding is decided from
// registered state alone.
//
// Optional build macro: FWD_CTRL_STATS_EN adds saturating forward/stall
// counters (fwd_count, stall_count). Without it those ports do not exist.
//
// Handshake: none. The unit observes the ID stage every cycle; stall is a
// combinational request that the core honours in the same cycle by holding
// PC and IF/ID, while this unit inserts the EX bubble itself.
module fwd_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall
`ifdef FWD_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]      fwd_count,
    output logic [CNT_W-1:0]      stall_count
`endif
);

    // Mux select codes, matching the EX operand mux input order.
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    // EX shadow
    logic                  ex_valid_q,   ex_valid_d;
    logic [REG_ADDR_W-1:0] ex_rs_q,      ex_rs_d;
    logic [REG_ADDR_W-1:0] ex_rt_q,      ex_rt_d;
    logic                  ex_uses_rs_q, ex_uses_rs_d;
    logic                  ex_uses_rt_q, ex_uses_rt_d;
    logic [REG_ADDR_W-1:0] ex_dst_q,     ex_dst_d;
    logic                  ex_rw_q,      ex_rw_d;
    logic                  ex_mr_q,      ex_mr_d;
    // MEM shadow
    logic                  mem_valid_q,  mem_valid_d;
    logic [REG_ADDR_W-1:0] mem_dst_q,    mem_dst_d;
    logic                  mem_rw_q,     mem_rw_d;
    logic                  mem_mr_q,     mem_mr_d;
    // WB shadow
    logic                  wb_valid_q,   wb_valid_d;
    logic [REG_ADDR_W-1:0] wb_dst_q,     wb_dst_d;
    logic                  wb_rw_q,      wb_rw_d;

    logic ex_capture;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    // Load-use detection: the load in EX has no result yet for the ID reader.
    always_comb begin
        stall = id_valid && !flush && ex_valid_q && ex_mr_q && ex_rw_q &&
                (ex_dst_q != '0) &&
                ((id_uses_rs && (ex_dst_q == id_rs)) ||
                 (id_uses_rt && (ex_dst_q == id_rt)));
    end

    // Next shadow-pipeline state: ID into EX unless stalled/flushed/bubble.
    always_comb begin
        ex_capture   = id_valid && !stall && !flush;
        ex_valid_d   = ex_capture;
        ex_rs_d      = id_rs;
        ex_rt_d      = id_rt;
        ex_uses_rs_d = id_uses_rs;
        ex_uses_rt_d = id_uses_rt;
        ex_dst_d     = id_dst;
        ex_rw_d      = ex_capture && id_reg_write;
        ex_mr_d      = ex_capture && id_mem_read;

        mem_valid_d  = ex_valid_q;
        mem_dst_d    = ex_dst_q;
        mem_rw_d     = ex_rw_q;
        mem_mr_d     = ex_mr_q;

        wb_valid_d   = mem_valid_q;
        wb_dst_d     = mem_dst_q;
        wb_rw_d      = mem_rw_q;
    end

    // Shadow pipeline registers; advance every cycle, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
            ex_dst_q     <= '0;
            ex_rw_q      <= 1'b0;
            ex_mr_q      <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_dst_q    <= '0;
            mem_rw_q     <= 1'b0;
            mem_mr_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_dst_q     <= '0;
            wb_rw_q      <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_uses_rs_q <= ex_uses_rs_d;
            ex_uses_rt_q <= ex_uses_rt_d;
            ex_dst_q     <= ex_dst_d;
            ex_rw_q      <= ex_rw_d;
            ex_mr_q      <= ex_mr_d;
            mem_valid_q  <= mem_valid_d;
            mem_dst_q    <= mem_dst_d;
            mem_rw_q     <= mem_rw_d;
            mem_mr_q     <= mem_mr_d;
            wb_valid_q   <= wb_valid_d;
            wb_dst_q     <= wb_dst_d;
            wb_rw_q      <= wb_rw_d;
        end
    end

    // Forward selects from registered state only; MEM (newest) beats WB, $0 never forwarded.
    always_comb begin
        mem_fwd_ok = mem_valid_q && mem_rw_q && (mem_dst_q != '0);
        wb_fwd_ok  = wb_valid_q && wb_rw_q && (wb_dst_q != '0);
        fwd_a_sel  = SEL_RF;
        fwd_b_sel  = SEL_RF;
        if (ex_valid_q && ex_uses_rs_q) begin
            if (mem_fwd_ok && (mem_dst_q == ex_rs_q)) begin
                fwd_a_sel = SEL_MEM;
            end else if (wb_fwd_ok && (wb_dst_q == ex_rs_q)) begin
                fwd_a_sel = SEL_WB;
            end
        end
        if (ex_valid_q && ex_uses_rt_q) begin
            if (mem_fwd_ok && (mem_dst_q == ex_rt_q)) begin
                fwd_b_sel = SEL_MEM;
            end else if (wb_fwd_ok && (wb_dst_q == ex_rt_q)) begin
                fwd_b_sel = SEL_WB;
            end
        end
    end

`ifdef FWD_CTRL_STATS_EN
    logic [CNT_W-1:0] fwd_count_q,   fwd_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // Saturating counters: one forward event per cycle regardless of operand count.
    always_comb begin
        fwd_count_d   = fwd_count_q;
        stall_count_d = stall_count_q;
        if (((fwd_a_sel != SEL_RF) || (fwd_b_sel != SEL_RF)) && (fwd_count_q != '1)) begin
            fwd_count_d = fwd_count_q + 1'b1;
        end
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            fwd_count_q   <= fwd_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed testbench for fwd_ctrl_unit. Build with +define+FWD_CTRL_STATS_EN
// to also exercise the statistics counters.
module tb_fwd_ctrl_unit;

    localparam int RW = 5;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic [RW-1:0] id_dst;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          flush;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic          stall;
`ifdef FWD_CTRL_STATS_EN
    logic [CW-1:0] fwd_count;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] cnt_before;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fwd_ctrl_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall)
`ifdef FWD_CTRL_STATS_EN
        ,
        .fwd_count    (fwd_count),
        .stall_count  (stall_count)
`endif
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Invariant: a load result is never taken from MEM, and code 3 never appears.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ((((fwd_a_sel == 2'd2) || (fwd_b_sel == 2'd2)) && dut.mem_mr_q) ||
                (fwd_a_sel == 2'd3) || (fwd_b_sel == 2'd3)) begin
                n_fail++;
                $display("FAIL sel_invariant: a=%0d b=%0d mem_mr=%0b, required no MEM load forward and no code 3",
                         fwd_a_sel, fwd_b_sel, dut.mem_mr_q);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                            input logic urs, input logic urt, input logic [RW-1:0] dst,
                            input logic rw, input logic mr);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_dst       = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic drive_nop();
        drive_id(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive_nop();
        repeat (3) step();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        drive_nop();
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: a=%0d b=%0d stall=%0b, required 0 0 0", fwd_a_sel, fwd_b_sel, stall);
        end
`ifdef FWD_CTRL_STATS_EN
        n_checks++;
        if ((fwd_count !== '0) || (stall_count !== '0)) begin
            n_fail++;
            $display("FAIL reset_counters: fwd=%0d stall=%0d, required 0 0", fwd_count, stall_count);
        end
`endif
        step();
        step();
        rst = 1'b0;
        step();
        // add $5 ; lw $5 reading $5 ; add reading $5 waits in ID
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        n_checks++;
        if (fwd_a_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_pre_fwd_a: got %0d, required 2", fwd_a_sel);
        end
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_stall: got %0b, required 1", stall);
        end
        // asynchronous reset, away from a clock edge
        rst = 1'b1;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: a=%0d b=%0d stall=%0b, required 0 0 0", fwd_a_sel, fwd_b_sel, stall);
        end
        drive_nop();
        step();
        rst = 1'b0;
        drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_post_stall: got %0b, required 0", stall);
        end
        step();
        drive_nop();
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_post_sel: a=%0d b=%0d, required 0 0", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_ex_mem_fwd();
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        step();
        drive_id(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // sub $8,$3,$7
        step();
        drive_nop();
        n_checks++;
        if ((fwd_a_sel !== 2'd2) || (fwd_b_sel !== 2'd0)) begin
            n_fail++;
            $display("FAIL ex_mem_fwd: a=%0d b=%0d, required 2 0", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_wb_fwd();
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3
        step();
        drive_nop();
        step();
        drive_id(1'b1, 5'd9, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // or $10,$9,$3
        step();
        drive_nop();
        n_checks++;
        if ((fwd_a_sel !== 2'd0) || (fwd_b_sel !== 2'd1)) begin
            n_fail++;
            $display("FAIL wb_fwd: a=%0d b=%0d, required 0 1", fwd_a_sel, fwd_b_sel);
        end
        // priority: two producers of $3 in flight
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 5'd3, 5'd11, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0); // and $12,$3,$11
        step();
        drive_nop();
        n_checks++;
        if ((fwd_a_sel !== 2'd2) || (fwd_b_sel !== 2'd0)) begin
            n_fail++;
            $display("FAIL mem_priority: a=%0d b=%0d, required 2 0", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use();
        drain();
`ifdef FWD_CTRL_STATS_EN
        cnt_before = stall_count;
`endif
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);   // lw $4
        step();
        drive_id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add $6,$4,$4
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: got %0b, required 1", stall);
        end
        step();                                                     // bubble enters EX, ID held
        n_checks++;
        if ((stall !== 1'b0) || (fwd_a_sel !== 2'd0) || (fwd_b_sel !== 2'd0)) begin
            n_fail++;
            $display("FAIL load_use_bubble: stall=%0b a=%0d b=%0d, required 0 0 0", stall, fwd_a_sel, fwd_b_sel);
        end
        step();
        drive_nop();
        n_checks++;
        if ((fwd_a_sel !== 2'd1) || (fwd_b_sel !== 2'd1)) begin
            n_fail++;
            $display("FAIL load_use_fwd: a=%0d b=%0d, required 1 1", fwd_a_sel, fwd_b_sel);
        end
`ifdef FWD_CTRL_STATS_EN
        n_checks++;
        if (stall_count !== cnt_before + 16'd1) begin
            n_fail++;
            $display("FAIL load_use_stall_count: got %0d, required %0d", stall_count, cnt_before + 16'd1);
        end
`endif
    endtask

    task automatic test_reg_zero();
        drain();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // add $0
        step();
        drive_id(1'b1, 5'd0, 5'd13, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
        step();
        drive_nop();
        n_checks++;
        if ((fwd_a_sel !== 2'd0) || (fwd_b_sel !== 2'd0)) begin
            n_fail++;
            $display("FAIL zero_fwd: a=%0d b=%0d, required 0 0", fwd_a_sel, fwd_b_sel);
        end
        drain();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw $0
        step();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_stall: got %0b, required 0", stall);
        end
        step();
        drive_nop();
    endtask

    task automatic test_flush();
        drain();
`ifdef FWD_CTRL_STATS_EN
        cnt_before = stall_count;
`endif
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);   // lw $4
        step();
        drive_id(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add $6,$4,$2
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got %0b, required 0", stall);
        end
        step();
        flush = 1'b0;
        drive_nop();
        n_checks++;
        if ((fwd_a_sel !== 2'd0) || (fwd_b_sel !== 2'd0)) begin
            n_fail++;
            $display("FAIL flush_sel_1: a=%0d b=%0d, required 0 0", fwd_a_sel, fwd_b_sel);
        end
        step();
        n_checks++;
        if ((fwd_a_sel !== 2'd0) || (fwd_b_sel !== 2'd0)) begin
            n_fail++;
            $display("FAIL flush_sel_2: a=%0d b=%0d, required 0 0", fwd_a_sel, fwd_b_sel);
        end
`ifdef FWD_CTRL_STATS_EN
        n_checks++;
        if (stall_count !== cnt_before) begin
            n_fail++;
            $display("FAIL flush_stall_count: got %0d, required %0d", stall_count, cnt_before);
        end
`endif
    endtask

    task automatic test_back_to_back();
        drain();
`ifdef FWD_CTRL_STATS_EN
        cnt_before = fwd_count;
`endif
        drive_id(1'b1, 5'd20, 5'd21, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0); // add $1
        step();
        drive_id(1'b1, 5'd1, 5'd22, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);  // add $2,$1,$22
        step();
        n_checks++;
        if ((fwd_a_sel !== 2'd2) || (fwd_b_sel !== 2'd0)) begin
            n_fail++;
            $display("FAIL b2b_first: a=%0d b=%0d, required 2 0", fwd_a_sel, fwd_b_sel);
        end
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
        step();
        drive_nop();
        n_checks++;
        if ((fwd_a_sel !== 2'd1) || (fwd_b_sel !== 2'd2)) begin
            n_fail++;
            $display("FAIL b2b_second: a=%0d b=%0d, required 1 2", fwd_a_sel, fwd_b_sel);
        end
        step();
`ifdef FWD_CTRL_STATS_EN
        n_checks++;
        if (fwd_count !== cnt_before + 16'd2) begin
            n_fail++;
            $display("FAIL b2b_fwd_count: got %0d, required %0d", fwd_count, cnt_before + 16'd2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ex_mem_fwd();
        test_wb_fwd();
        test_load_use();
        test_reg_zero();
        test_flush();
        test_back_to_back();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
